wb_uart_cmd_master: RTL and testbench
=====================================

// Module: wb_uart_cmd_master
// PURPOSE
//  Byte-stream-to-Wishbone bus master for debug and program loading. It takes
//  command bytes from a UART receiver, runs single 32-bit Wishbone read/write
//  cycles, and returns response bytes to a UART transmitter. It connects to
//  the free master port m2 of wb_conmax_top, beside the core's i/d masters.
// PARAMETERS
//  ACK_TIMEOUT  1024  cycles wb_cyc_o may wait for ack/err before abort (2..65535)
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst        in   1   asynchronous active-low reset
//  rx_data_i  in   8   received byte
//  rx_valid_i in   1   rx_data_i valid
//  rx_ready_o out  1   byte accepted when rx_valid_i && rx_ready_o
//  tx_data_o  out  8   response byte
//  tx_valid_o out  1   tx_data_o valid; held stable until tx_ready_i
//  tx_ready_i in   1   transmitter takes byte when tx_valid_o && tx_ready_i
//  wb_adr_o   out  32  Wishbone address
//  wb_dat_o   out  32  Wishbone write data
//  wb_dat_i   in   32  Wishbone read data
//  wb_sel_o   out  4   byte select; always 4'hF during a cycle, else 0
//  wb_we_o    out  1   1 = write cycle
//  wb_cyc_o   out  1   bus cycle
//  wb_stb_o   out  1   strobe; equal to wb_cyc_o
//  wb_ack_i   in   1   slave acknowledge
//  wb_err_i   in   1   slave error
//  busy_o     out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs and registers go to 0; state IDLE. rst low mid-transaction
//   drops wb_cyc_o/wb_stb_o/tx_valid_o at once and discards the partial command.
//  Protocol (multi-byte fields MSB first):
//   'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0 -> write; reply 'K'(0x4B) or 'E'(0x45)
//   'R'(0x52) A3 A2 A1 A0 -> read; reply D3 D2 D1 D0 or a single 'E'
//   any other first byte -> reply '?'(0x3F); return to IDLE
//  States: IDLE, GET_ADDR, GET_DATA, BUS, RESP.
//   IDLE: rx_ready_o=1. 'W' or 'R' latches we and goes to GET_ADDR.
//    Other bytes load '?' and go to RESP.
//   GET_ADDR: rx_ready_o=1; shifts 4 bytes into the address register.
//    After the 4th: GET_DATA if write, else BUS.
//   GET_DATA: rx_ready_o=1; shifts 4 bytes into the data register, then BUS.
//   BUS: rx_ready_o=0. wb_cyc_o=wb_stb_o=1 from the cycle after the last byte
//    is accepted. adr/dat/we/sel are stable for the whole cycle.
//    Wait counter starts at 0 on entry and increments each cycle.
//    Exit conditions, sampled on clk:
//    - wb_err_i=1: load 'E'.
//    - else wb_ack_i=1: capture wb_dat_i on a read; load 'K' on a write.
//    - else counter==ACK_TIMEOUT-1: load 'E'.
//    Priority: err > ack > timeout.
//    On exit, wb_cyc_o/wb_stb_o/wb_sel_o go to 0 on the next cycle (registered).
//    Next state is RESP.
//   RESP: tx_valid_o=1 with the current byte. Each tx_ready_i handshake moves
//    to the next byte. Read success sends 4 bytes; every other reply sends 1.
//    After the last handshake: IDLE, tx_valid_o=0.
//  Minimum write latency: wb_cyc_o rises 1 cycle after D0 is accepted.
//  Zero-wait slave (ack in the first BUS cycle): wb_cyc_o is high for exactly 1 cycle.
//  tx_ready_i stuck low: stays in RESP indefinitely; rx stays not-ready (no overrun).
//  rx bytes are never dropped silently. Bytes arriving while not ready are
//   held off by the upstream FIFO.
//  wb_dat_i is ignored on write cycles and on err/timeout.
// TESTING
//  1 Send 57 00 00 00 10 DE AD BE EF with a slave acking after 2 waits.
//    -> one cycle: adr=0x10, dat=0xDEADBEEF, we=1, sel=F, cyc high 3 clk.
//    -> reply 0x4B.
//  2 Send 52 00 00 20 00; slave returns 0x12345678 with a zero-wait ack.
//    -> cyc high 1 clk, we=0.
//    -> tx 12 34 56 78 in order, each held until tx_ready_i.
//  3 Send 52 00 00 00 00; slave never acks, ACK_TIMEOUT=16.
//    -> cyc drops exactly 16 clk after it rose; reply single 0x45.
//  4 Send 0x41.
//    -> reply 0x3F, no bus cycle.
//    -> next 'R' command completes normally.
//  5 Assert ack and err together; separately assert ack on the final timeout cycle.
//    -> reply 0x45 for the first case, 0x4B for the second.
//  6 Pull rst low during BUS, then during RESP with tx_ready_i=0.
//    -> all outputs 0 immediately.
//    -> after release, a fresh 'W' command completes correctly.

Source files
------------

// File: rtl/wb_uart_cmd_master.sv
// Byte-stream command interpreter that runs single 32-bit Wishbone read/write
// cycles and returns the reply bytes through a UART transmitter handshake.
module wb_uart_cmd_master #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS,
        RESP
    } state_t;

    localparam logic [7:0]  CMD_W     = 8'h57;
    localparam logic [7:0]  CMD_R     = 8'h52;
    localparam logic [7:0]  RSP_K     = 8'h4B;
    localparam logic [7:0]  RSP_E     = 8'h45;
    localparam logic [7:0]  RSP_Q     = 8'h3F;
    localparam logic [15:0] WAIT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] wait_q, wait_d;
    logic [31:0] resp_q, resp_d;     // reply bytes, current one in [31:24]
    logic [1:0]  resp_left_q, resp_left_d;
    logic        rx_fire;
    logic        tx_fire;

    assign rx_ready_o = (state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA);
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign tx_valid_o = (state_q == RESP);
    assign tx_fire    = tx_valid_o && tx_ready_i;
    assign tx_data_o  = resp_q[31:24];
    assign busy_o     = (state_q != IDLE);

    // Bus strobes decode straight from the state register, so they rise the
    // cycle after the last command byte and fall the cycle after exit.
    assign wb_cyc_o = (state_q == BUS);
    assign wb_stb_o = wb_cyc_o;
    assign wb_sel_o = wb_cyc_o ? 4'hF : 4'h0;
    assign wb_we_o  = wb_cyc_o && we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;

    // NOTE: every variable gets its hold value before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        byte_cnt_d  = byte_cnt_q;
        wait_d      = wait_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    if (rx_data_i == CMD_W || rx_data_i == CMD_R) begin
                        we_d       = (rx_data_i == CMD_W);
                        byte_cnt_d = 2'd0;
                        state_d    = GET_ADDR;
                    end else begin
                        resp_d      = {RSP_Q, 24'h0};
                        resp_left_d = 2'd0;
                        state_d     = RESP;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_fire) begin
                    adr_d      = {adr_q[23:0], rx_data_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wait_d  = 16'd0;
                        state_d = we_q ? GET_DATA : BUS;
                    end
                end
            end
            GET_DATA: begin
                if (rx_fire) begin
                    dat_d      = {dat_q[23:0], rx_data_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wait_d  = 16'd0;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                wait_d = wait_q + 16'd1;
                // Error outranks acknowledge, which outranks the timeout.
                if (wb_err_i) begin
                    resp_d      = {RSP_E, 24'h0};
                    resp_left_d = 2'd0;
                    state_d     = RESP;
                end else if (wb_ack_i) begin
                    resp_d      = we_q ? {RSP_K, 24'h0} : wb_dat_i;
                    resp_left_d = we_q ? 2'd0 : 2'd3;
                    state_d     = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    resp_d      = {RSP_E, 24'h0};
                    resp_left_d = 2'd0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (tx_fire) begin
                    if (resp_left_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        resp_d      = {resp_q[23:0], 8'h00};
                        resp_left_d = resp_left_q - 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register, including the data holding registers, so a reset mid-command leaves nothing stale on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            byte_cnt_q  <= 2'd0;
            wait_q      <= 16'd0;
            resp_q      <= 32'h0;
            resp_left_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            byte_cnt_q  <= byte_cnt_d;
            wait_q      <= wait_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
        end
    end

endmodule

// File: tb/tb_wb_uart_cmd_master.sv
// Self-checking bench for wb_uart_cmd_master: directed protocol cases plus
// randomized commands checked against a command-level reply/bus model.
module tb_wb_uart_cmd_master;

    localparam int T = 16;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_NONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_m;
    logic [31:0] wb_dat_s = 32'h0;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    wb_uart_cmd_master #(.ACK_TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_m),
        .wb_dat_i   (wb_dat_s),
        .wb_sel_o   (wb_sel),
        .wb_we_o    (wb_we),
        .wb_cyc_o   (wb_cyc),
        .wb_stb_o   (wb_stb),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Slave behaviour and bus monitor, evaluated on the falling edge.
    int          slv_mode  = M_NONE;
    int          slv_delay = 0;
    logic [31:0] slv_rdata = 32'h0;
    bit          in_cyc    = 1'b0;
    int          cyc_len   = 0;
    int          cycles_seen = 0;
    int          unstable  = 0;
    logic [31:0] mon_adr, mon_dat;
    logic        mon_we;
    logic [3:0]  mon_sel;

    always @(negedge clk) begin
        if (wb_cyc) begin
            if (!in_cyc) begin
                in_cyc  = 1'b1;
                cyc_len = 1;
                cycles_seen++;
                mon_adr = wb_adr;
                mon_dat = wb_dat_m;
                mon_we  = wb_we;
                mon_sel = wb_sel;
            end else begin
                cyc_len++;
                if (wb_adr !== mon_adr || wb_dat_m !== mon_dat || wb_we !== mon_we || wb_sel !== mon_sel)
                    unstable++;
            end
            if (wb_stb !== wb_cyc) unstable++;
            wb_ack   = (slv_mode == M_ACK || slv_mode == M_BOTH) && (cyc_len - 1 == slv_delay);
            wb_err   = (slv_mode == M_ERR || slv_mode == M_BOTH) && (cyc_len - 1 == slv_delay);
            wb_dat_s = (wb_ack && !wb_err) ? slv_rdata : $urandom;
        end else begin
            in_cyc = 1'b0;
            wb_ack = 1'b0;
            wb_err = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Command-level reference: what the reply and bus cycle should look like.
    logic [7:0] exp_rep[4];
    int         exp_n;
    int         exp_len;
    bit         exp_bus;

    task automatic model(input logic [7:0] cmd, input int mode, input int delay, input logic [31:0] rd);
        bit acked;
        exp_bus = (cmd == 8'h57 || cmd == 8'h52);
        exp_len = 0;
        exp_n   = 1;
        if (!exp_bus) begin
            exp_rep[0] = 8'h3F;
        end else begin
            acked   = (mode != M_NONE) && (delay < T);
            exp_len = acked ? delay + 1 : T;
            if (!acked || mode == M_ERR || mode == M_BOTH) exp_rep[0] = 8'h45;
            else if (cmd == 8'h57) exp_rep[0] = 8'h4B;
            else begin
                exp_n = 4;
                for (int i = 0; i < 4; i++) exp_rep[i] = rd[31 - 8*i -: 8];
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("rx_accept_wait", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic get_reply();
        logic [7:0] got;
        int t;
        int stall;
        for (int i = 0; i < exp_n; i++) begin
            t = 0;
            while (!tx_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("reply_wait", tx_valid, 1);
            got   = tx_data;
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("tx_hold", {tx_valid, tx_data}, {1'b1, got});
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            check($sformatf("reply_byte%0d", i), got, exp_rep[i]);
        end
        check("idle_after_reply", {tx_valid, busy, rx_ready}, 3'b001);
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                           input int mode, input int delay, input logic [31:0] rd);
        int seen0;
        int t;
        model(cmd, mode, delay, rd);
        slv_mode  = mode;
        slv_delay = delay;
        slv_rdata = rd;
        seen0     = cycles_seen;
        send_byte(cmd);
        if (exp_bus) begin
            for (int i = 0; i < 4; i++) send_byte(a[31 - 8*i -: 8]);
            if (cmd == 8'h57)
                for (int i = 0; i < 4; i++) send_byte(d[31 - 8*i -: 8]);
            check("cyc_rise_latency", {wb_cyc, rx_ready}, 2'b10);
            t = 0;
            while (wb_cyc && t < T + 20) begin
                @(negedge clk);
                t++;
            end
            check("cyc_fall_wait", wb_cyc, 0);
            check("cyc_len", 64'(cyc_len), 64'(exp_len));
            check("bus_adr", mon_adr, a);
            check("bus_we_sel", {mon_we, mon_sel}, {cmd == 8'h57, 4'hF});
            if (cmd == 8'h57) check("bus_dat", mon_dat, d);
            check("bus_stable", 64'(unstable), 0);
            check("sel_after", wb_sel, 4'h0);
            check("cycle_count", 64'(cycles_seen), 64'(seen0 + 1));
        end else begin
            check("no_bus_cycle", 64'(cycles_seen), 64'(seen0));
        end
        get_reply();
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [31:0] ra, rd, rr;
        int          kind;

        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {wb_cyc, wb_stb, wb_sel, wb_we, tx_valid, busy, tx_data},
              {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00});
        check("reset_bus", {wb_adr, wb_dat_m}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", {rx_ready, busy}, 2'b10);

        // Write with two wait states, zero-wait read, timeout, bad command.
        run_cmd(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, M_ACK, 2, 32'h0);
        run_cmd(8'h52, 32'h0000_2000, 32'h0, M_ACK, 0, 32'h1234_5678);
        run_cmd(8'h52, 32'h0000_0000, 32'h0, M_NONE, 0, 32'h0);
        run_cmd(8'h41, 32'h0, 32'h0, M_NONE, 0, 32'h0);
        run_cmd(8'h52, 32'hCAFE_0004, 32'h0, M_ACK, 1, 32'hA5C3_0F96);
        // ack+err together, then ack on the last timeout cycle.
        run_cmd(8'h57, 32'h0000_0100, 32'h1111_2222, M_BOTH, 1, 32'h0);
        run_cmd(8'h57, 32'h0000_0104, 32'h3333_4444, M_ACK, T - 1, 32'h0);
        run_cmd(8'h52, 32'h0000_0108, 32'h0, M_ERR, 3, 32'hFFFF_FFFF);

        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 4);
            ra   = $urandom;
            rd   = $urandom;
            rr   = $urandom;
            if (kind <= 1) cmd = 8'h57;
            else if (kind <= 3) cmd = 8'h52;
            else begin
                cmd = 8'($urandom);
                while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
            end
            run_cmd(cmd, ra, rd, $urandom_range(0, 3), $urandom_range(0, T + 2), rr);
        end

        // Reset while the bus cycle is waiting on a silent slave.
        slv_mode = M_NONE;
        send_byte(8'h57);
        for (int i = 0; i < 8; i++) send_byte(8'h5A);
        @(negedge clk);
        check("bus_before_reset", wb_cyc, 1);
        #2 rst = 1'b0;
        #1 check("reset_in_bus", {wb_cyc, wb_stb, wb_sel, wb_we, tx_valid, busy},
                 {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0});
        check("reset_in_bus_regs", {wb_adr, wb_dat_m}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_cmd(8'h57, 32'h0000_0200, 32'h0BAD_F00D, M_ACK, 1, 32'h0);

        // Reply stalled by the transmitter, then reset during the reply.
        send_byte(8'h41);
        repeat (4) begin
            @(negedge clk);
            check("stalled_resp", {tx_valid, tx_data, rx_ready}, {1'b1, 8'h3F, 1'b0});
        end
        #2 rst = 1'b0;
        #1 check("reset_in_resp", {tx_valid, tx_data, busy, wb_cyc}, {1'b0, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_cmd(8'h57, 32'h0000_0300, 32'h7654_3210, M_ACK, 0, 32'h0);
        run_cmd(8'h52, 32'h0000_0300, 32'h0, M_ACK, 2, 32'h7654_3210);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
